// File: rtl/infra_sensor_debounce_if.sv
// Signal bundle between the IR sensor pin and the PIO and motor logic.
// The master drives the raw pin and the clear strobe. The slave (the
// debouncer) returns the clean level, the edge pulses and the event count.
interface infra_sensor_debounce_if #(
  parameter int EVT_W = 16
) ();
  logic             sensor_raw;
  logic             clr_events;
  logic             sensor_clean;
  logic             obstacle_rise;
  logic             obstacle_fall;
  logic [EVT_W-1:0] event_count;

  modport master (
    output sensor_raw,
    output clr_events,
    input  sensor_clean,
    input  obstacle_rise,
    input  obstacle_fall,
    input  event_count
  );

  modport slave (
    input  sensor_raw,
    input  clr_events,
    output sensor_clean,
    output obstacle_rise,
    output obstacle_fall,
    output event_count
  );
endinterface

// File: rtl/infra_sensor_debounce.sv
// IR obstacle sensor conditioning stage.
// The raw pin is synchronised and its polarity normalised so that
// obstacle = 1. A change is accepted only when it persists for
// DEBOUNCE_CYCLES consecutive cycles. The block then drives a clean level,
// one-cycle edge pulses and a saturating count of obstacle events.
module infra_sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EVT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  infra_sensor_debounce_if.slave bus
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             ff1_q;
  logic             ff2_q;
  logic             s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;
  logic             rise_q;
  logic             fall_q;
  logic [EVT_W-1:0] evt_q;
  logic [EVT_W-1:0] evt_d;

  // Two-flop synchroniser. Reset loads the idle pin level, so s starts at 0.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff1_q <= ACTIVE_LOW;
      ff2_q <= ACTIVE_LOW;
    end else begin
      ff1_q <= bus.sensor_raw;
      ff2_q <= ff1_q;
    end
  end

  // Normalised level with obstacle = 1. Only the second stage is consumed.
  assign s = ff2_q ^ ACTIVE_LOW;

  // Qualify FSM with registered clean level and edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (s != clean_q) begin
            state_q <= ST_QUALIFY;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_QUALIFY: begin
          if (s == clean_q) begin
            // The excursion ended early. Drop it without any visible effect.
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            clean_q <= s;
            rise_q  <= s;
            fall_q  <= ~s;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Next event count. It counts each rise pulse and saturates. A clear that
  // coincides with a rise keeps that new event.
  // NOTE: evt_d gets a default first so no path through this block can infer a latch.
  always_comb begin
    evt_d = evt_q;
    if (bus.clr_events) begin
      evt_d = rise_q ? EVT_W'(1) : '0;
    end else if (rise_q && (evt_q != '1)) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  // Event count register.
  always_ff @(posedge clk) begin
    if (reset) evt_q <= '0;
    else       evt_q <= evt_d;
  end

  assign bus.sensor_clean  = clean_q;
  assign bus.obstacle_rise = rise_q;
  assign bus.obstacle_fall = fall_q;
  assign bus.event_count   = evt_q;

endmodule

// File: tb/tb_infra_sensor_debounce.sv
// Bench for infra_sensor_debounce with DEBOUNCE_CYCLES=4 and EVT_W=4.
// Two instances run side by side. Instance 0 uses an active-low pin.
// Instance 1 uses an active-high pin driven with the inverted stimulus.
module tb_infra_sensor_debounce;

  localparam int D   = 4;
  localparam int EW  = 4;
  localparam int MAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw = 1'b1;
  logic clr = 1'b0;
  bit   chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  infra_sensor_debounce_if #(.EVT_W(EW)) bus0 ();
  infra_sensor_debounce_if #(.EVT_W(EW)) bus1 ();

  assign bus0.sensor_raw = raw;
  assign bus0.clr_events = clr;
  assign bus1.sensor_raw = ~raw;
  assign bus1.clr_events = clr;

  infra_sensor_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(16), .EVT_W(EW), .ACTIVE_LOW(1'b1))
    dut0 (.clk(clk), .reset(rst), .bus(bus0));
  infra_sensor_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(16), .EVT_W(EW), .ACTIVE_LOW(1'b0))
    dut1 (.clk(clk), .reset(rst), .bus(bus1));

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Each instance keeps a window of the last D normalised
  // samples. The clean level flips once all D samples in the window
  // disagree with it.
  bit             al [2] = '{1'b1, 1'b0};
  logic           m_s1 [2];
  logic           m_s2 [2];
  logic           m_clean [2];
  logic           m_rise [2];
  logic           m_fall [2];
  int             m_ev [2];
  logic [D-1:0]   m_win [2];
  int             m_nval [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic raw_k;
      logic s;
      raw_k = (k == 0) ? raw : ~raw;
      if (rst) begin
        m_s1[k] = al[k]; m_s2[k] = al[k];
        m_clean[k] = 1'b0; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
        m_ev[k] = 0; m_win[k] = '0; m_nval[k] = 0;
      end else begin
        s = m_s2[k] ^ al[k];
        if (clr)                       m_ev[k] = m_rise[k] ? 1 : 0;
        else if (m_rise[k] && m_ev[k] < MAX) m_ev[k] = m_ev[k] + 1;
        m_win[k] = {m_win[k][D-2:0], s};
        if (m_nval[k] < D) m_nval[k] = m_nval[k] + 1;
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        if (m_nval[k] == D && m_win[k] == {D{~m_clean[k]}}) begin
          m_clean[k] = s;
          m_rise[k]  = s;
          m_fall[k]  = ~s;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = raw_k;
      end
    end
  end

  // Compare both instances against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("clean0", int'(bus0.sensor_clean),  int'(m_clean[0]));
      check("rise0",  int'(bus0.obstacle_rise), int'(m_rise[0]));
      check("fall0",  int'(bus0.obstacle_fall), int'(m_fall[0]));
      check("count0", int'(bus0.event_count),   m_ev[0]);
      check("dual0",  int'(bus0.obstacle_rise & bus0.obstacle_fall), 0);
      check("clean1", int'(bus1.sensor_clean),  int'(m_clean[1]));
      check("rise1",  int'(bus1.obstacle_rise), int'(m_rise[1]));
      check("fall1",  int'(bus1.obstacle_fall), int'(m_fall[1]));
      check("count1", int'(bus1.event_count),   m_ev[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int len;

    // Scenario 1: reset with the pin idle, then idle for 20 cycles.
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("s1_clean", int'(bus0.sensor_clean), 0);
    check("s1_count", int'(bus0.event_count), 0);

    // Scenario 2: clean assert, latency measured from the first sampling edge.
    raw = 1'b0;
    n = 0;
    while (!bus0.sensor_clean && n < 20) begin
      tick(1);
      n++;
    end
    check("s2_latency", n, D + 2);
    tick(6);
    check("s2_count", int'(bus0.event_count), 1);
    raw = 1'b1;
    tick(12);

    // Scenario 3: low pulses of 1 to 3 cycles are rejected. A 4-cycle pulse is accepted.
    for (int w = 1; w <= D; w++) begin
      raw = 1'b0; tick(w);
      raw = 1'b1; tick(12);
    end
    check("s3_count", int'(bus0.event_count), 2);

    // Scenario 4: saturation, clear, and a clear that coincides with a rise.
    for (int i = 0; i < 17; i++) begin
      raw = 1'b0; tick(8);
      raw = 1'b1; tick(8);
    end
    check("s4_sat", int'(bus0.event_count), MAX);
    clr = 1'b1; tick(1); clr = 1'b0;
    tick(2);
    check("s4_clr", int'(bus0.event_count), 0);
    raw = 1'b0;
    n = 0;
    while (!m_rise[0] && n < 20) begin
      tick(1);
      n++;
    end
    check("s4_rise_seen", int'(n < 20), 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("s4_clr_rise", int'(bus0.event_count), 1);
    tick(4);
    raw = 1'b1; tick(12);

    // Scenario 5: reset while qualifying with cnt=2, then requalify from scratch.
    raw = 1'b0;
    tick(4);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("s5_clean_rst", int'(bus0.sensor_clean), 0);
    n = 0;
    while (!bus0.sensor_clean && n < 20) begin
      tick(1);
      n++;
    end
    check("s5_latency", n, D + 2);
    tick(4);
    raw = 1'b1; tick(12);

    // Randomised traffic: run lengths, occasional clears and resets.
    for (int i = 0; i < 800; i++) begin
      len = $urandom_range(1, 7);
      raw = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
      clr = 1'b0;
      rst = 1'b0;
      if (len > 1) tick(len - 1);
    end

    tick(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
